// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the pipe_MIPS32 core and its
//               hazard-detection / forwarding controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Default architectural sizing of the core
   localparam int NREG_DEF  = 32;
   localparam int RAW_DEF   = $clog2(NREG_DEF);
   localparam int DEPTH_DEF = 3;
   localparam int SELW_DEF  = $clog2(DEPTH_DEF + 1);

   // Shadow entries store tags at a fixed width so the type can be shared
   // by every instance. Narrower register numbers are zero-extended.
   // This limits NREG to 256 or fewer.
   localparam int TAG_W = 8;

   // One in-flight instruction as seen by the hazard unit
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] dest;
      logic             is_load;
   } hz_entry_t;

   // Opcodes shared with pipe_MIPS32
   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

endpackage
`default_nettype wire

// File: rtl/mips_hz_match.sv
`default_nettype none
// ============================================================================
// Module      : mips_hz_match
// Description : Youngest-match priority encoder. It searches the shadow
//               pipeline for the most recent in-flight writer of one source
//               register.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_hz_match
   import mips_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int SELW  = $clog2(DEPTH + 1)
) (
   input  hz_entry_t [DEPTH-1:0] shadow,
   input  logic [TAG_W-1:0]      src,
   input  logic                  used,
   output logic                  hit,
   output logic [SELW-1:0]       stage,
   output logic                  is_load
);

   // Scan from oldest to youngest so that the youngest match is the last write
   always_comb begin
      hit     = 1'b0;
      stage   = '0;
      is_load = 1'b0;
      if (used && (src != '0)) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (shadow[k].valid && (shadow[k].dest == src)) begin
               hit     = 1'b1;
               stage   = SELW'(k);
               is_load = shadow[k].is_load;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_unit
// Description : Hazard-detection and forwarding controller for pipe_MIPS32.
//               It tracks destination tags of in-flight instructions, selects
//               forwarding sources, raises the load-use stall and honours
//               branch flush.
//               Optional: define HAZARD_STATS_EN to add the stall_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_hazard_unit
   import mips_pkg::*;
#(
   parameter int NREG     = 32,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int RAW      = $clog2(NREG),
   parameter int SELW     = $clog2(DEPTH + 1)
) (
   input  logic            clk1,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [RAW-1:0]  id_rs,
   input  logic [RAW-1:0]  id_rt,
   input  logic            id_rs_used,
   input  logic            id_rt_used,
   input  logic [RAW-1:0]  id_rd,
   input  logic            id_wr,
   input  logic            id_is_load,
   input  logic            flush,
   output logic            stall,
   output logic [SELW-1:0] fwd_rs_sel,
   output logic [SELW-1:0] fwd_rt_sel
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]     stall_count
`endif
);

   localparam logic [SELW-1:0] C_LOAD_LAT = SELW'(LOAD_LAT);

   hz_entry_t [DEPTH-1:0] r_shadow;
   hz_entry_t             w_new;

   logic            w_rs_hit, w_rt_hit;
   logic            w_rs_ld, w_rt_ld;
   logic [SELW-1:0] w_rs_stage, w_rt_stage;
   logic            w_rs_lu, w_rt_lu;

   mips_hz_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_rs (
      .shadow  (r_shadow),
      .src     (TAG_W'(id_rs)),
      .used    (id_rs_used),
      .hit     (w_rs_hit),
      .stage   (w_rs_stage),
      .is_load (w_rs_ld)
   );

   mips_hz_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_rt (
      .shadow  (r_shadow),
      .src     (TAG_W'(id_rt)),
      .used    (id_rt_used),
      .hit     (w_rt_hit),
      .stage   (w_rt_stage),
      .is_load (w_rt_ld)
   );

   // The load result is not yet on any bus before stage LOAD_LAT
   assign w_rs_lu = w_rs_hit & w_rs_ld & (w_rs_stage < C_LOAD_LAT);
   assign w_rt_lu = w_rt_hit & w_rt_ld & (w_rt_stage < C_LOAD_LAT);

   // Flush wins over stall: a wrong-path instruction never holds the front end
   assign stall = id_valid & ~flush & (w_rs_lu | w_rt_lu);

   // Select the youngest writer's bus. The select is forced to 0 while stalled.
   always_comb begin
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
      if (!stall) begin
         if (w_rs_hit) fwd_rs_sel = w_rs_stage + SELW'(1);
         if (w_rt_hit) fwd_rt_sel = w_rt_stage + SELW'(1);
      end
   end

   // Entry recorded for the ID instruction. Stall, flush and R0 writes become bubbles.
   always_comb begin
      w_new.valid   = id_valid & id_wr & (id_rd != '0) & ~stall & ~flush;
      w_new.dest    = TAG_W'(id_rd);
      w_new.is_load = id_is_load;
   end

   // Shadow pipeline. Older entries always advance and the WB entry drops off.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else begin
         r_shadow <= {r_shadow[DEPTH-2:0], w_new};
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_count;

   // Saturating count of stalled cycles
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= '0;
      end else if (stall && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: doc/mips_hazard_unit.md
# mips_hazard_unit

Parametrised hazard-detection and forwarding controller for the pipe_MIPS32 core, replacing the dummy-instruction padding that programs currently need between dependent instructions. Sits beside the ID stage. Tracks destination tags of in-flight instructions in a depth-parametrised shadow pipeline. Produces per-source forwarding selects and a load-use stall, and accepts a branch flush.

## Interface
Parameters:
- NREG, 32: architectural registers; tag width RAW = $clog2(NREG).
- DEPTH, 3: tracked stages after ID; stage 0 = EX, stage DEPTH-1 = WB.
- LOAD_LAT, 1: first stage index whose result bus carries load data; 1 ≤ LOAD_LAT < DEPTH.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  RAW  source register numbers.
- id_rs_used, id_rt_used  in  1  source is actually read.
- id_rd  in  RAW  destination register.
- id_wr  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is LW.
- flush  in  1  taken branch; ID instruction is wrong-path.
- stall  out  1  hold PC and IF/ID, inject bubble into EX.
- fwd_rs_sel, fwd_rt_sel  out  $clog2(DEPTH+1)  0 = register file, k+1 = result bus of stage k.
- stall_count  out  32  present only with HAZARD_STATS_EN.

## Operation
- Shadow pipeline: DEPTH entries, each holding {valid, dest, is_load}.
- Each clock, stage k ← stage k-1 for k ≥ 1. The entry leaving stage DEPTH-1 is discarded, since it has been written back.
- Stage 0 ← {id_valid & id_wr & (id_rd≠0) & ~stall & ~flush, id_rd, id_is_load}. A stall or flush therefore inserts a bubble. Older entries always advance, including during stall.
- Match for a source s: consider only if used and s ≠ 0. Take the youngest stage k (smallest index) with valid and dest == s. Older matches are ignored.
- No match → sel = 0. Match at k → sel = k+1.
- Load-use: if the matched youngest entry has is_load and k < LOAD_LAT, assert stall. While stalled, sel is don't-care and is driven 0.
- stall = id_valid & ~flush & (rs load-use | rt load-use).
- flush has priority over stall: stall = 0 and the ID entry is not recorded.
- R0 is never a hazard, whether as source or destination.

## Timing
- stall and fwd_*_sel are combinational from ID inputs and registered shadow state, valid in the same cycle.
- Shadow state updates on the clk1 rising edge.
- Load-use costs exactly LOAD_LAT - k bubble cycles. Default: one cycle for LW immediately followed by a consumer.
- Reset: all entries invalid, stall_count = 0. Outputs at reset: stall = 0, fwd_rs_sel = fwd_rt_sel = 0.
- Reset asserted mid-operation clears in-flight tags immediately. The first instruction after release sees no hazards.
- Simultaneous flush + load-use: no stall, bubble inserted.

## Configuration
- HAZARD_STATS_EN defined: stall_count increments on every cycle with stall = 1 and saturates at 32'hFFFFFFFF. It is cleared by rst_n.
- HAZARD_STATS_EN undefined: the port and counter are absent. No other behavioural difference.

## Structure
- mips_pkg holds:
  - the RAW and selector-width constants;
  - hz_entry_t {valid, dest, is_load};
  - opcode constants shared with pipe_MIPS32.
- Sub-module mips_hz_match: a combinational youngest-match priority encoder. It takes the shadow array plus one source and returns {hit, stage, is_load}. It is instantiated twice, once for rs and once for rt.
- Shadow pipeline and stats counter live in the top module.

## Test plan
- ADDI R1,R0,120 then LW R2,0(R1) back-to-back → second cycle fwd_rs_sel = 1, stall = 0.
- LW R2,0(R1) then ADDI R2,R2,45 → stall = 1 for one cycle, then fwd_rs_sel = 2, stall = 0. Final Mem[121] = 130 when Mem[120] = 85 in the full core, with no dummy ORs.
- Destination R0 (ADDI R0,R0,5) followed by a reader of R0 → fwd_rs_sel = 0, stall = 0.
- Two older writers to R3 at stages 0 and 2 → fwd_rt_sel = 1 (youngest wins). After the younger writer is flushed → fwd_rt_sel = 3.
- flush asserted with a load-use pending → stall = 0, and the next cycle shows no entry for that instruction.
- Reset pulse mid-program with 3 valid entries → outputs 0 immediately. With HAZARD_STATS_EN: stall_count 0, and it counts 4 after four forced load-use cycles.
